// File: rtl/axis_rr_arbiter.sv
// Frame-granular round-robin merge of two MAC RX AXIS ports into the ibuf writer.
// Stamps the source port into tuser[23:16] and counts delivered frames per port.
module axis_rr_arbiter #(
  parameter logic [7:0] SRC_PORT0 = 8'h01,
  parameter logic [7:0] SRC_PORT1 = 8'h04,
  parameter int         CNT_W     = 32
) (
  input  logic             s_axis_aclk,
  input  logic             s_axis_aresetp,
  input  logic             ctrl_en,
  input  logic [63:0]      s0_axis_tdata,
  input  logic [7:0]       s0_axis_tstrb,
  input  logic [127:0]     s0_axis_tuser,
  input  logic             s0_axis_tvalid,
  input  logic             s0_axis_tlast,
  output logic             s0_axis_tready,
  input  logic [63:0]      s1_axis_tdata,
  input  logic [7:0]       s1_axis_tstrb,
  input  logic [127:0]     s1_axis_tuser,
  input  logic             s1_axis_tvalid,
  input  logic             s1_axis_tlast,
  output logic             s1_axis_tready,
  output logic [63:0]      m_axis_tdata,
  output logic [7:0]       m_axis_tstrb,
  output logic [127:0]     m_axis_tuser,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  input  logic             m_axis_tready,
  output logic [CNT_W-1:0] frames0,
  output logic [CNT_W-1:0] frames1,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_G0   = 3'b010,
    S_G1   = 3'b100
  } state_t;

  state_t state;
  state_t state_nx;
  logic   last_grant;
  logic   in_frame;
  logic   in_frame_nx;
  logic   end0;
  logic   end1;
  logic   unused_stamp_bits;

  // The incoming stamp field is overwritten with the source port id.
  assign unused_stamp_bits = ^{s0_axis_tuser[23:16],
                               s1_axis_tuser[23:16]};

  always_comb begin
    state_nx       = state;
    in_frame_nx    = in_frame;
    end0           = 1'b0;
    end1           = 1'b0;
    busy           = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    m_axis_tdata   = '0;
    m_axis_tstrb   = '0;
    m_axis_tuser   = '0;
    m_axis_tvalid  = 1'b0;
    m_axis_tlast   = 1'b0;
    unique case (1'b1)
      state == S_IDLE: begin
        in_frame_nx = 1'b0;
        if (ctrl_en && s0_axis_tvalid &&
            (!s1_axis_tvalid || last_grant))
          state_nx = S_G0;
        else if (ctrl_en && s1_axis_tvalid)
          state_nx = S_G1;
      end
      state == S_G0: begin
        busy           = 1'b1;
        m_axis_tdata   = s0_axis_tdata;
        m_axis_tstrb   = s0_axis_tstrb;
        m_axis_tvalid  = s0_axis_tvalid;
        m_axis_tlast   = s0_axis_tlast;
        m_axis_tuser   = {s0_axis_tuser[127:24], SRC_PORT0,
                          s0_axis_tuser[15:0]};
        s0_axis_tready = m_axis_tready;
        if (s0_axis_tvalid && m_axis_tready) begin
          in_frame_nx = !s0_axis_tlast;
          if (s0_axis_tlast) begin
            end0 = 1'b1;
            if (ctrl_en && s1_axis_tvalid)
              state_nx = S_G1;
            else if (ctrl_en && s0_axis_tvalid)
              state_nx = S_G0;
            else
              state_nx = S_IDLE;
          end
        end else if (!in_frame && !s0_axis_tvalid) begin
          // Re-granted after a frame but nothing followed: release.
          state_nx = S_IDLE;
        end
      end
      state == S_G1: begin
        busy           = 1'b1;
        m_axis_tdata   = s1_axis_tdata;
        m_axis_tstrb   = s1_axis_tstrb;
        m_axis_tvalid  = s1_axis_tvalid;
        m_axis_tlast   = s1_axis_tlast;
        m_axis_tuser   = {s1_axis_tuser[127:24], SRC_PORT1,
                          s1_axis_tuser[15:0]};
        s1_axis_tready = m_axis_tready;
        if (s1_axis_tvalid && m_axis_tready) begin
          in_frame_nx = !s1_axis_tlast;
          if (s1_axis_tlast) begin
            end1 = 1'b1;
            if (ctrl_en && s0_axis_tvalid)
              state_nx = S_G0;
            else if (ctrl_en && s1_axis_tvalid)
              state_nx = S_G1;
            else
              state_nx = S_IDLE;
          end
        end else if (!in_frame && !s1_axis_tvalid) begin
          state_nx = S_IDLE;
        end
      end
      default: begin
        state_nx    = S_IDLE;
        in_frame_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge s_axis_aclk or posedge s_axis_aresetp) begin
    if (s_axis_aresetp) begin
      state      <= S_IDLE;
      in_frame   <= 1'b0;
      last_grant <= 1'b1;
      frames0    <= '0;
      frames1    <= '0;
    end else begin
      state    <= state_nx;
      in_frame <= in_frame_nx;
      if (end0) begin
        last_grant <= 1'b0;
        frames0    <= frames0 + CNT_W'(1);
      end
      if (end1) begin
        last_grant <= 1'b1;
        frames1    <= frames1 + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Bench for axis_rr_arbiter: scenario table, scoreboard and
// hand-written ctrl_en and mid-frame reset sequences.
module tb_axis_rr_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ctrl_en = 1'b0;
  logic [63:0]  d0 = '0, d1 = '0, md;
  logic [7:0]   k0 = '0, k1 = '0, mk;
  logic [127:0] u0 = '0, u1 = '0, mu;
  logic         v0 = 1'b0, v1 = 1'b0, l0 = 1'b0, l1 = 1'b0;
  logic         r0, r1, mv, ml;
  logic         mr = 1'b0;
  logic [31:0]  f0, f1;
  logic         busy;

  always #5 clk = ~clk;

  axis_rr_arbiter dut (
    .s_axis_aclk    (clk),
    .s_axis_aresetp (rst),
    .ctrl_en        (ctrl_en),
    .s0_axis_tdata  (d0),
    .s0_axis_tstrb  (k0),
    .s0_axis_tuser  (u0),
    .s0_axis_tvalid (v0),
    .s0_axis_tlast  (l0),
    .s0_axis_tready (r0),
    .s1_axis_tdata  (d1),
    .s1_axis_tstrb  (k1),
    .s1_axis_tuser  (u1),
    .s1_axis_tvalid (v1),
    .s1_axis_tlast  (l1),
    .s1_axis_tready (r1),
    .m_axis_tdata   (md),
    .m_axis_tstrb   (mk),
    .m_axis_tuser   (mu),
    .m_axis_tvalid  (mv),
    .m_axis_tlast   (ml),
    .m_axis_tready  (mr),
    .frames0        (f0),
    .frames1        (f1),
    .busy           (busy)
  );

  typedef struct packed {
    logic [63:0]  data;
    logic [7:0]   strb;
    logic [127:0] user;
    logic         last;
  } beat_t;

  typedef struct {
    int          n0, b0, n1, b1, rmode;
    logic [15:0] ord;
    int          nord, ef0, ef1, span;
  } vec_t;

  beat_t q0[$], q1[$];
  int    ord_q[$];
  int    total = 0, bad = 0;
  int    cyc = 0, hs_cnt = 0, first_hs = 0, last_hs = 0;
  int    cur_port = -1, mp, rmode = 0;
  bit    in_fr = 1'b0, abort = 1'b0;
  beat_t mgot, mexp;

  task automatic chk(input string name, input logic [255:0] act,
                     input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk); #1;
    if (rmode == 1) mr = ~mr;
    else mr = (rmode == 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Scoreboard monitor: samples mid-cycle, between drive and edge.
  always @(negedge clk) begin
    if (rst) begin
      in_fr = 1'b0;
      hs_cnt = 0;
      q0.delete();
      q1.delete();
      ord_q.delete();
    end else begin
      chk("tready_excl", 256'(r0 & r1), 256'(0));
      if (in_fr && cur_port == 1) chk("s0_hold", 256'(r0), 256'(0));
      if (in_fr && cur_port == 0) chk("s1_hold", 256'(r1), 256'(0));
      if (mv && mr) begin
        mp = (md[63:56] == 8'hA1) ? 1 : 0;
        mgot = '{md, mk, mu, ml};
        if (!in_fr) begin
          if (ord_q.size() == 0) chk("order", 256'(mp), 256'(99));
          else chk("order", 256'(mp), 256'(ord_q.pop_front()));
          cur_port = mp;
        end else begin
          chk("no_interleave", 256'(mp), 256'(cur_port));
        end
        if ((mp == 1) ? q1.size() == 0 : q0.size() == 0) begin
          chk("extra_beat", 256'(1), 256'(0));
        end else begin
          mexp = (mp == 1) ? q1.pop_front() : q0.pop_front();
          chk("beat", 256'(mgot), 256'(mexp));
        end
        in_fr = !ml;
        if (hs_cnt == 0) first_hs = cyc;
        last_hs = cyc;
        hs_cnt++;
      end
    end
  end

  task automatic send(input int p, input int nfr, input int nb);
    beat_t bt;
    logic [127:0] u;
    int w;
    bit hs;
    for (int f = 0; f < nfr; f++) begin
      for (int b = 0; b < nb; b++) begin
        u = {$urandom, $urandom, $urandom, $urandom};
        bt.data = {(p == 1) ? 8'hA1 : 8'hA0, 8'(f), 16'(b), $urandom};
        bt.strb = 8'($urandom);
        bt.last = (b == nb - 1);
        bt.user = u;
        bt.user[23:16] = (p == 1) ? 8'h04 : 8'h01;
        if (p == 1) begin
          d1 = bt.data; k1 = bt.strb; u1 = u; l1 = bt.last; v1 = 1'b1;
          q1.push_back(bt);
        end else begin
          d0 = bt.data; k0 = bt.strb; u0 = u; l0 = bt.last; v0 = 1'b1;
          q0.push_back(bt);
        end
        w = 0;
        do begin
          @(negedge clk);
          hs = (p == 1) ? r1 : r0;
          @(posedge clk); #1;
          w++;
          if (abort || w > 3000) begin
            if (!abort) chk("send_timeout", 256'(w), 256'(0));
            if (p == 1) v1 = 1'b0;
            else v0 = 1'b0;
            return;
          end
        end while (!hs);
      end
    end
    if (p == 1) v1 = 1'b0;
    else v0 = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    v0 = 1'b0;
    v1 = 1'b0;
    abort = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    int w;
    w = 0;
    while (hs_cnt < n && w < 500) begin
      @(posedge clk); #1;
      w++;
    end
    chk("wait_beats", 256'(hs_cnt >= n), 256'(1));
  endtask

  vec_t V[4];
  int   start, idle_bad;

  initial begin
    V[0] = '{n0:1, b0:4, n1:0, b1:1, rmode:0, ord:16'b0,
             nord:1, ef0:1, ef1:0, span:3};
    V[1] = '{n0:4, b0:3, n1:4, b1:3, rmode:0, ord:16'b10101010,
             nord:8, ef0:4, ef1:4, span:23};
    V[2] = '{n0:3, b0:1, n1:0, b1:1, rmode:0, ord:16'b0,
             nord:3, ef0:3, ef1:0, span:2};
    V[3] = '{n0:2, b0:2, n1:2, b1:5, rmode:1, ord:16'b1010,
             nord:4, ef0:2, ef1:2, span:-1};

    // Reset state with both ports requesting.
    ctrl_en = 1'b1;
    v0 = 1'b1;
    v1 = 1'b1;
    #12;
    chk("rst_mvalid", 256'(mv), 256'(0));
    chk("rst_r0", 256'(r0), 256'(0));
    chk("rst_r1", 256'(r1), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_f0", 256'(f0), 256'(0));
    chk("rst_f1", 256'(f1), 256'(0));

    for (int i = 0; i < 4; i++) begin
      do_reset();
      ctrl_en = 1'b1;
      rmode = V[i].rmode;
      for (int k = 0; k < V[i].nord; k++) ord_q.push_back(int'(V[i].ord[k]));
      @(posedge clk); #1;
      start = cyc;
      fork
        send(0, V[i].n0, V[i].b0);
        send(1, V[i].n1, V[i].b1);
        begin
          @(negedge clk);
          chk("grant_cycle_mvalid", 256'(mv), 256'(0));
        end
      join
      repeat (4) @(posedge clk);
      #1;
      chk("v_frames0", 256'(f0), 256'(V[i].ef0));
      chk("v_frames1", 256'(f1), 256'(V[i].ef1));
      chk("v_idle_busy", 256'(busy), 256'(0));
      chk("v_idle_mvalid", 256'(mv), 256'(0));
      chk("v_order_left", 256'(ord_q.size()), 256'(0));
      chk("v_beats_left", 256'(q0.size() + q1.size()), 256'(0));
      if (V[i].span >= 0) begin
        chk("v_latency", 256'(first_hs - start), 256'(1));
        chk("v_span", 256'(last_hs - first_hs), 256'(V[i].span));
      end
    end

    // ctrl_en dropped mid-frame, held low, then reasserted.
    do_reset();
    rmode = 0;
    ctrl_en = 1'b1;
    ord_q.push_back(0);
    ord_q.push_back(1);
    ord_q.push_back(0);
    @(posedge clk); #1;
    fork
      send(0, 2, 5);
      send(1, 1, 2);
      begin
        wait_beats(2);
        ctrl_en = 1'b0;
        wait_beats(5);
        idle_bad = 0;
        repeat (10) begin
          @(negedge clk);
          if (busy || mv || r0 || r1) idle_bad++;
        end
        chk("hold_idle", 256'(idle_bad), 256'(0));
        chk("ce_frames0_mid", 256'(f0), 256'(1));
        chk("ce_frames1_mid", 256'(f1), 256'(0));
        @(posedge clk); #1;
        ctrl_en = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    chk("ce_frames0", 256'(f0), 256'(2));
    chk("ce_frames1", 256'(f1), 256'(1));
    chk("ce_order_left", 256'(ord_q.size()), 256'(0));

    // Reset asserted on beat 3 of a 6-beat frame.
    do_reset();
    ctrl_en = 1'b1;
    ord_q.push_back(0);
    ord_q.push_back(1);
    @(posedge clk); #1;
    send(0, 1, 2);
    fork
      send(1, 1, 6);
      begin
        wait_beats(5);
        chk("pre_rst_f0", 256'(f0), 256'(1));
        chk("pre_rst_r1", 256'(r1), 256'(1));
        #2;
        rst = 1'b1;
        abort = 1'b1;
        #1;
        chk("arst_mvalid", 256'(mv), 256'(0));
        chk("arst_r0", 256'(r0), 256'(0));
        chk("arst_r1", 256'(r1), 256'(0));
        chk("arst_busy", 256'(busy), 256'(0));
        chk("arst_f0", 256'(f0), 256'(0));
      end
    join
    do_reset();
    ord_q.push_back(0);
    ord_q.push_back(1);
    @(posedge clk); #1;
    fork
      send(0, 1, 2);
      send(1, 1, 2);
    join
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_f0", 256'(f0), 256'(1));
    chk("post_rst_f1", 256'(f1), 256'(1));
    chk("post_rst_order", 256'(ord_q.size()), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
